// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: two-stage valid/ready immediate extender with SEXT, ZEXT, LUI and BOFF modes.
module imm_extend_pipe #(
   parameter int IN_W     = 16,
   parameter int OUT_W    = 32,
   parameter int BR_SHIFT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_mode,
   input  logic [IN_W-1:0]  in_S,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_S,
   output logic             out_neg
);
   logic             v1, v2, adv1, adv2;
   logic [IN_W-1:0]  s1;
   logic [1:0]       m1;
   logic [OUT_W-1:0] zx, sx, res;
   assign adv2      = !v2 || out_ready;
   assign adv1      = !v1 || adv2;
   assign in_ready  = adv1;
   assign out_valid = v2;
   assign out_neg   = out_S[OUT_W-1];
   // size casts widen without zero-width replications when OUT_W == IN_W
   assign zx = OUT_W'(s1);
   assign sx = OUT_W'($signed(s1));
   always_comb
      res = (m1 == 2'd0) ? sx :
            (m1 == 2'd1) ? zx :
            (m1 == 2'd2) ? zx << (OUT_W - IN_W) :
                           sx << BR_SHIFT;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v1    <= 1'b0;
         v2    <= 1'b0;
         s1    <= '0;
         m1    <= '0;
         out_S <= '0;
      end else begin
         if (adv2) begin
            v2    <= v1;
            out_S <= res;
         end
         if (adv1) begin
            v1 <= in_valid;
            if (in_valid) begin
               s1 <= in_S;
               m1 <= in_mode;
            end
         end
      end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: scoreboard bench for the default and an 8-to-16 instance of imm_extend_pipe.
module tb_imm_extend_pipe;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b1;
   logic [1:0]  in_mode = 2'd0;
   logic [15:0] in_S = 16'h0;
   logic        in_ready, out_valid, out_neg;
   logic [31:0] out_S;
   logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_neg8;
   logic [1:0]  in_mode8 = 2'd0;
   logic [7:0]  in_S8 = 8'h0;
   logic [15:0] out_S8;
   int          checks = 0, failures = 0, cyc = 0, stalls = 0;
   bit          lat_chk = 1'b0;
   typedef struct {logic [31:0] v; int t;} item_t;
   item_t       q[$];
   item_t       it;
   logic [15:0] q8[$];
   logic [15:0] e8;

   always #5 clk = ~clk;

   imm_extend_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_S(in_S), .out_valid(out_valid), .out_ready(out_ready),
      .out_S(out_S), .out_neg(out_neg));

   imm_extend_pipe #(.IN_W(8), .OUT_W(16), .BR_SHIFT(1)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .in_mode(in_mode8), .in_S(in_S8), .out_valid(out_valid8), .out_ready(1'b1),
      .out_S(out_S8), .out_neg(out_neg8));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model32(input logic [1:0] m, input logic [15:0] x);
      case (m)
         2'd0:    return {{16{x[15]}}, x};
         2'd1:    return {16'h0000, x};
         2'd2:    return {x, 16'h0000};
         default: return {{14{x[15]}}, x, 2'b00};
      endcase
   endfunction

   function automatic logic [15:0] model8(input logic [1:0] m, input logic [7:0] x);
      case (m)
         2'd0:    return {{8{x[7]}}, x};
         2'd1:    return {8'h00, x};
         2'd2:    return {x, 8'h00};
         default: return {{7{x[7]}}, x, 1'b0};
      endcase
   endfunction

   // inputs only change at posedge+1, so the negedge sees what the next edge will transfer
   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_out", {31'b0, out_valid}, 32'd0);
            else begin
               it = q.pop_front();
               chk("out_S", out_S, it.v);
               chk("out_neg", {31'b0, out_neg}, {31'b0, it.v[31]});
               if (lat_chk) chk("latency", cyc - it.t, 32'd2);
            end
         end
         if (in_valid && in_ready) q.push_back('{model32(in_mode, in_S), cyc});
         if (out_valid8) begin
            if (q8.size() == 0) chk("spurious_out8", {31'b0, out_valid8}, 32'd0);
            else begin
               e8 = q8.pop_front();
               chk("out_S8", {16'h0, out_S8}, {16'h0, e8});
               chk("out_neg8", {31'b0, out_neg8}, {31'b0, e8[15]});
            end
         end
         if (in_valid8 && in_ready8) q8.push_back(model8(in_mode8, in_S8));
      end
   end

   task automatic put(input logic [1:0] m, input logic [15:0] x);
      int n = 0;
      @(posedge clk) #1;
      in_valid = 1'b1; in_mode = m; in_S = x;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      stalls += n;
      if (n == 50) chk("accept_timeout", {31'b0, in_ready}, 32'd1);
   endtask

   task automatic idle();
      @(posedge clk) #1;
      in_valid = 1'b0; in_valid8 = 1'b0; in_S = 16'($urandom);
   endtask

   task automatic put8(input logic [1:0] m, input logic [7:0] x);
      @(posedge clk) #1;
      in_valid8 = 1'b1; in_mode8 = m; in_S8 = x;
      @(negedge clk);
      if (!in_ready8) chk("accept8", {31'b0, in_ready8}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 3; i++) begin
         @(posedge clk) #1;
         in_valid = 1'($urandom); in_mode = 2'($urandom); in_S = 16'($urandom);
         in_valid8 = 1'($urandom); in_mode8 = 2'($urandom); in_S8 = 8'($urandom);
         @(negedge clk);
         chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
         chk("rst_out_S", out_S, 32'd0);
         chk("rst_out_neg", {31'b0, out_neg}, 32'd0);
         chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
         chk("rst_out_valid8", {31'b0, out_valid8}, 32'd0);
      end
      in_valid = 1'b0; in_valid8 = 1'b0;
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("rel_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rel_out_S", out_S, 32'd0);
      chk("rel_in_ready", {31'b0, in_ready}, 32'd1);

      lat_chk = 1'b1;
      put(2'd0, 16'h8000); put(2'd0, 16'h0001); put(2'd1, 16'h8000);
      put(2'd2, 16'h1234); put(2'd3, 16'hFFFF); put(2'd3, 16'h0004);
      idle();
      repeat (4) @(posedge clk);
      lat_chk = 1'b0;

      @(posedge clk) #1 out_ready = 1'b0;
      fork
         begin
            put(2'd0, 16'h0001); put(2'd0, 16'h0002); put(2'd0, 16'h0003);
            idle();
         end
         begin
            repeat (4) @(posedge clk);
            #2;
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_hold", out_S, 32'h00000001);
            @(posedge clk) #2;
            chk("bp_stable", out_S, 32'h00000001);
            out_ready = 1'b1;
         end
      join
      repeat (5) @(posedge clk);

      #1 out_ready = 1'b0;
      put(2'd0, 16'h0011); put(2'd1, 16'h0022);
      idle();
      #1 chk("full_in_ready", {31'b0, in_ready}, 32'd0);
      out_ready = 1'b1;
      #1 chk("full_pass", {31'b0, in_ready}, 32'd1);
      stalls = 0;
      for (int i = 0; i < 10; i++) put(2'($urandom), 16'($urandom));
      idle();
      chk("stream_stalls", stalls, 32'd0);
      repeat (4) @(posedge clk);

      put(2'd0, 16'hAAAA); put(2'd1, 16'h5555);
      @(posedge clk) #2;
      in_valid = 1'b0;
      rst_n = 1'b0;
      q.delete(); q8.delete();
      #1;
      chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("mid_rst_out_S", out_S, 32'd0);
      chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
      #4 rst_n = 1'b1;
      lat_chk = 1'b1;
      put(2'd2, 16'h00C3);
      idle();
      repeat (4) @(posedge clk);
      lat_chk = 1'b0;

      put8(2'd0, 8'h80); put8(2'd2, 8'h7F); put8(2'd3, 8'hC0); put8(2'd1, 8'hF0);
      idle();

      for (int i = 0; i < 20 && (q.size() != 0 || q8.size() != 0); i++) @(posedge clk);
      repeat (2) @(posedge clk);
      chk("drain", q.size(), 32'd0);
      chk("drain8", q8.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised, pipelined immediate-extension unit. It is the successor to the fixed 16-to-32 combinational sign extender. It widens an IN_W-bit immediate to OUT_W bits in one of four modes: sign-extend, zero-extend, load-upper and branch offset. It sits between instruction decode and the ALU/branch-target path of the pipelined core, using a two-stage valid/ready pipeline with backpressure.

Parameters:
IN_W, 16, immediate input width; legal range 1..OUT_W.
OUT_W, 32, extended output width; must satisfy OUT_W >= IN_W.
BR_SHIFT, 2, left shift applied in branch-offset mode; legal range 0..OUT_W-1.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream holds a valid immediate.
in_ready  output  1  unit can accept this cycle.
in_mode  input  2  0=SEXT, 1=ZEXT, 2=LUI, 3=BOFF.
in_S  input  IN_W  raw immediate.
out_valid  output  1  out_S/out_neg valid.
out_ready  input  1  downstream accepts this cycle.
out_S  output  OUT_W  extended result.
out_neg  output  1  copy of out_S[OUT_W-1].

Behaviour:
- Reset (rst_n low, asynchronous):
  - Stage valids v1 and v2, all data registers, out_S, out_neg and out_valid go to 0.
  - in_ready = 1 while rst_n is low and after release (pipeline empty).
- Handshakes:
  - Input transfer on a rising edge with in_valid && in_ready.
  - Output transfer on a rising edge with out_valid && out_ready.
  - in_mode and in_S are sampled only on an input transfer.
- Stage 1 registers in_S, in_mode and v1.
- Stage 2 registers the computed result and v2. out_valid = v2.
- Advance rules:
  - adv2 = !v2 || out_ready.
  - adv1 = !v1 || adv2.
  - in_ready = adv1 (combinational path out_ready -> in_ready is permitted).
- Stage 2 update: when adv2 is true, v2 <= v1 and result <= f(stage-1 data). When adv2 is false, v2 and the result hold.
- Stage 1 update: when adv1 is true, v1 <= in_valid and the data loads if in_valid. When adv1 is false, stage 1 holds.
- Latency and throughput:
  - Input accepted at edge k -> out_valid with its result after edge k+1, provided out_ready was high at that edge.
  - Throughput is 1 per cycle.
  - Order is strictly preserved; no drops or duplicates under any backpressure pattern.
- Output stability: out_S/out_neg stay stable while out_valid && !out_ready.
- f(x, mode):
  - SEXT: {(OUT_W-IN_W) copies of x[IN_W-1], x}.
  - ZEXT: {(OUT_W-IN_W) zeros, x}.
  - LUI: {x, (OUT_W-IN_W) zeros}. If OUT_W == IN_W, the result is x.
  - BOFF: SEXT(x) shifted left by BR_SHIFT, truncated to OUT_W. Shifted-out MSBs are discarded; BR_SHIFT zeros fill the LSBs.
  - All four modes are defined; there is no illegal-mode state.
- Edge cases:
  - OUT_W == IN_W: SEXT and ZEXT pass x unchanged.
  - Full pipe (v1 = v2 = 1) with out_ready = 0: in_ready = 0 and both stages hold.
  - Full pipe with out_ready = 1: a simultaneous output transfer, stage shift and input transfer occur on the same edge.
  - Reset asserted mid-stream: in-flight data is discarded immediately and out_valid drops asynchronously. After release, the first accepted input has normal 2-cycle latency.
  - in_valid deasserted between items creates bubbles. Bubbles never produce out_valid.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_S=0, out_neg=0, in_ready=1. Release -> unchanged until the first transfer.
- Modes (IN_W=16, OUT_W=32, out_ready=1), back-to-back every cycle:
  - SEXT 0x8000 -> 0xFFFF8000 (out_neg=1); SEXT 0x0001 -> 0x00000001.
  - ZEXT 0x8000 -> 0x00008000 (out_neg=0).
  - LUI 0x1234 -> 0x12340000.
  - BOFF 0xFFFF -> 0xFFFFFFFC; BOFF 0x0004 -> 0x00000010.
  - Results appear 2 edges after acceptance, one per cycle, in order.
- Backpressure:
  - Send 0x0001, 0x0002, 0x0003 SEXT with out_ready=0 for 4 cycles -> in_ready falls after 2 accepts; out_S holds 0x00000001 stable.
  - Raise out_ready -> 1, 2, 3 delivered in order with no loss.
- Simultaneous events: with the pipe full, drive out_ready=1 and in_valid=1 every cycle for 10 items -> 10 outputs in order at 1 per cycle, in_ready constantly 1.
- Mid-stream reset: 2 items in flight, pulse rst_n low between clock edges -> out_valid drops immediately. The next item after release appears with 2-cycle latency; old data never reappears.
- Parametrised instance (IN_W=8, OUT_W=16, BR_SHIFT=1):
  - SEXT 0x80 -> 0xFF80.
  - LUI 0x7F -> 0x7F00.
  - BOFF 0xC0 -> 0xFF80.
